// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port ALU share, 2-cycle latency; define ALU_ARB_RR_EN for round-robin, else fixed priority
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int CTRW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [CTRW-1:0]  req0_ctr,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [CTRW-1:0]  req1_ctr,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [CTRW-1:0]  alu_ctr,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);
    logic iss_vld, iss_id;
`ifdef ALU_ARB_RR_EN
    logic ptr;
    always_comb begin
        req0_ready = !reset && req0_valid && (!req1_valid || !ptr);
        req1_ready = !reset && req1_valid && (!req0_valid || ptr);
    end
    always_ff @(posedge clk)
        if (reset)
            ptr <= 1'b0;
        else if (req0_ready || req1_ready)
            ptr <= req0_ready;
`else
    always_comb begin
        req0_ready = !reset && req0_valid;
        req1_ready = !reset && req1_valid && !req0_valid;
    end
`endif
    // ALU operands hold their last value when nothing is accepted
    always_ff @(posedge clk)
        if (reset) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_ctr <= '0;
            iss_vld <= 1'b0;
            iss_id  <= 1'b0;
        end else begin
            iss_vld <= req0_ready || req1_ready;
            if (req0_ready || req1_ready) begin
                alu_a   <= req1_ready ? req1_a : req0_a;
                alu_b   <= req1_ready ? req1_b : req0_b;
                alu_ctr <= req1_ready ? req1_ctr : req0_ctr;
                iss_id  <= req1_ready;
            end
        end
    always_ff @(posedge clk)
        if (reset) begin
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp0_zero   <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
            rsp1_zero   <= 1'b0;
        end else begin
            rsp0_valid <= iss_vld && !iss_id;
            rsp1_valid <= iss_vld && iss_id;
            if (iss_vld && !iss_id) begin
                rsp0_result <= alu_result;
                rsp0_zero   <= alu_zero;
            end
            if (iss_vld && iss_id) begin
                rsp1_result <= alu_result;
                rsp1_zero   <= alu_zero;
            end
        end
endmodule
